// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: stall hold, flush bubble, valid-gated control.
// Optional bubble/stall statistics counters under ID_EX_PERF_CNT_EN.
module id_ex_reg #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          valid_in,
   input  logic          MemtoReg_in,
   input  logic          RegWrite_in,
   input  logic          MemRead_in,
   input  logic          MemWrite_in,
   input  logic          RegDst_in,
   input  logic          ALUSrc_in,
   input  logic [1:0]    ALUOp_in,
   input  logic [DW-1:0] rd1_in,
   input  logic [DW-1:0] rd2_in,
   input  logic [DW-1:0] imm_in,
   input  logic [DW-1:0] pc4_in,
   input  logic [RW-1:0] rs_in,
   input  logic [RW-1:0] rt_in,
   input  logic [RW-1:0] rd_in,
   output logic          MemtoReg_out,
   output logic          RegWrite_out,
   output logic          MemRead_out,
   output logic          MemWrite_out,
   output logic          RegDst_out,
   output logic          ALUSrc_out,
   output logic [1:0]    ALUOp_out,
   output logic [DW-1:0] rd1_out,
   output logic [DW-1:0] rd2_out,
   output logic [DW-1:0] imm_out,
   output logic [DW-1:0] pc4_out,
   output logic [RW-1:0] rs_out,
   output logic [RW-1:0] rt_out,
   output logic [RW-1:0] rd_out,
   output logic          valid_out
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [15:0]   bubble_cnt,
   output logic [15:0]   stall_cnt
`endif
);

   // Control bits packed as {MemtoReg, RegWrite, MemRead, MemWrite, RegDst, ALUSrc, ALUOp}
   logic [7:0]    ctrl_in_s;
   logic [7:0]    ctrl_r,  ctrl_nxt_s;
   logic          valid_r, valid_nxt_s;
   logic [DW-1:0] rd1_r, rd1_nxt_s;
   logic [DW-1:0] rd2_r, rd2_nxt_s;
   logic [DW-1:0] imm_r, imm_nxt_s;
   logic [DW-1:0] pc4_r, pc4_nxt_s;
   logic [RW-1:0] rs_r,  rs_nxt_s;
   logic [RW-1:0] rt_r,  rt_nxt_s;
   logic [RW-1:0] rd_r,  rd_nxt_s;

   assign ctrl_in_s = {MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in,
                       RegDst_in, ALUSrc_in, ALUOp_in};

   // Next-state selection: flush beats stall, stall beats load
   always_comb begin
      ctrl_nxt_s  = ctrl_r;
      valid_nxt_s = valid_r;
      rd1_nxt_s   = rd1_r;
      rd2_nxt_s   = rd2_r;
      imm_nxt_s   = imm_r;
      pc4_nxt_s   = pc4_r;
      rs_nxt_s    = rs_r;
      rt_nxt_s    = rt_r;
      rd_nxt_s    = rd_r;
      if (flush) begin
         ctrl_nxt_s  = 8'h00;
         valid_nxt_s = 1'b0;
         rd1_nxt_s   = {DW{1'b0}};
         rd2_nxt_s   = {DW{1'b0}};
         imm_nxt_s   = {DW{1'b0}};
         pc4_nxt_s   = {DW{1'b0}};
         rs_nxt_s    = {RW{1'b0}};
         rt_nxt_s    = {RW{1'b0}};
         rd_nxt_s    = {RW{1'b0}};
      end else if (stall) begin
         ctrl_nxt_s  = ctrl_r;
         valid_nxt_s = valid_r;
      end else begin
         // Control is gated by valid so a non-real entry can never carry side effects
         if (valid_in) begin
            ctrl_nxt_s = ctrl_in_s;
         end else begin
            ctrl_nxt_s = 8'h00;
         end
         valid_nxt_s = valid_in;
         rd1_nxt_s   = rd1_in;
         rd2_nxt_s   = rd2_in;
         imm_nxt_s   = imm_in;
         pc4_nxt_s   = pc4_in;
         rs_nxt_s    = rs_in;
         rt_nxt_s    = rt_in;
         rd_nxt_s    = rd_in;
      end
   end

   // Pipeline state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r  <= 8'h00;
         valid_r <= 1'b0;
         rd1_r   <= {DW{1'b0}};
         rd2_r   <= {DW{1'b0}};
         imm_r   <= {DW{1'b0}};
         pc4_r   <= {DW{1'b0}};
         rs_r    <= {RW{1'b0}};
         rt_r    <= {RW{1'b0}};
         rd_r    <= {RW{1'b0}};
      end else begin
         ctrl_r  <= ctrl_nxt_s;
         valid_r <= valid_nxt_s;
         rd1_r   <= rd1_nxt_s;
         rd2_r   <= rd2_nxt_s;
         imm_r   <= imm_nxt_s;
         pc4_r   <= pc4_nxt_s;
         rs_r    <= rs_nxt_s;
         rt_r    <= rt_nxt_s;
         rd_r    <= rd_nxt_s;
      end
   end

   assign {MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
           RegDst_out, ALUSrc_out, ALUOp_out} = ctrl_r;
   assign valid_out = valid_r;
   assign rd1_out   = rd1_r;
   assign rd2_out   = rd2_r;
   assign imm_out   = imm_r;
   assign pc4_out   = pc4_r;
   assign rs_out    = rs_r;
   assign rt_out    = rt_r;
   assign rd_out    = rd_r;

`ifdef ID_EX_PERF_CNT_EN
   logic        bubble_ev_s;
   logic        stall_ev_s;
   logic [15:0] bubble_cnt_r;
   logic [15:0] stall_cnt_r;

   // A bubble is any non-reset edge that writes valid_out=0
   assign bubble_ev_s = flush | (~stall & ~valid_in);
   assign stall_ev_s  = stall & ~flush;

   // Saturating statistics counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_r <= 16'h0000;
         stall_cnt_r  <= 16'h0000;
      end else begin
         if (bubble_ev_s && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'd1;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
         if (stall_ev_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bubble_cnt = bubble_cnt_r;
   assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (counters checked when
// ID_EX_PERF_CNT_EN is defined).
module tb_id_ex_reg;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_in;
   logic [7:0]  ctrl_in;
   logic [31:0] rd1_in, rd2_in, imm_in, pc4_in;
   logic [4:0]  rs_in, rt_in, rd_in;

   logic        MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out;
   logic        RegDst_out, ALUSrc_out, valid_out;
   logic [1:0]  ALUOp_out;
   logic [31:0] rd1_out, rd2_out, imm_out, pc4_out;
   logic [4:0]  rs_out, rt_out, rd_out;
`ifdef ID_EX_PERF_CNT_EN
   logic [15:0] bubble_cnt, stall_cnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int exp_bubble = 0;
   int exp_stall = 0;

   wire [151:0] obs = {MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
                       RegDst_out, ALUSrc_out, ALUOp_out, rd1_out, rd2_out,
                       imm_out, pc4_out, rs_out, rt_out, rd_out, valid_out};

   id_ex_reg #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
      .MemtoReg_in(ctrl_in[7]), .RegWrite_in(ctrl_in[6]), .MemRead_in(ctrl_in[5]),
      .MemWrite_in(ctrl_in[4]), .RegDst_in(ctrl_in[3]), .ALUSrc_in(ctrl_in[2]),
      .ALUOp_in(ctrl_in[1:0]),
      .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc4_in(pc4_in),
      .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
      .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
      .RegDst_out(RegDst_out), .ALUSrc_out(ALUSrc_out), .ALUOp_out(ALUOp_out),
      .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .pc4_out(pc4_out),
      .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic [151:0] pack(input logic [7:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] i,
                                   input logic [31:0] p, input logic [4:0] s,
                                   input logic [4:0] t, input logic [4:0] d,
                                   input logic v);
      return {c, a, b, i, p, s, t, d, v};
   endfunction

   task automatic set_in(input logic v, input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] p, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d);
      valid_in = v; ctrl_in = c; rd1_in = a; rd2_in = b; imm_in = i; pc4_in = p;
      rs_in = s; rt_in = t; rd_in = d;
   endtask

   // One clock edge; bench counter model updated from the inputs applied at that edge
   task automatic step();
      if (rst) begin
         exp_bubble = 0; exp_stall = 0;
      end else if (flush) begin
         if (exp_bubble < 65535) exp_bubble++;
      end else if (stall) begin
         if (exp_stall < 65535) exp_stall++;
      end else if (!valid_in) begin
         if (exp_bubble < 65535) exp_bubble++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string name);
`ifdef ID_EX_PERF_CNT_EN
      tests_run++;
      if (bubble_cnt !== exp_bubble[15:0]) begin
         tests_failed++;
         $display("FAIL %s bubble_cnt got %0d want %0d", name, bubble_cnt, exp_bubble);
      end
      tests_run++;
      if (stall_cnt !== exp_stall[15:0]) begin
         tests_failed++;
         $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_stall);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      set_in(1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hAAAA_5555, 32'h0040_0004,
             5'd31, 5'd17, 5'd1);
      for (int k = 0; k < 2; k++) begin
         step();
         tests_run++;
         if (obs !== 152'd0) begin
            tests_failed++;
            $display("FAIL reset[%0d] got %h want 0", k, obs);
         end
      end
      check_cnt("reset");
      rst = 1'b0;
   endtask

   task automatic test_load();
      set_in(1'b1, 8'b0100_0010, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
      step();
      tests_run++;
      if ({RegWrite_out, ALUOp_out, rd1_out, rt_out, valid_out} !==
          {1'b1, 2'b10, 32'h0000_0005, 5'd9, 1'b1}) begin
         tests_failed++;
         $display("FAIL load_fields got RegWrite=%b ALUOp=%b rd1=%h rt=%0d valid=%b want 1 10 00000005 9 1",
                  RegWrite_out, ALUOp_out, rd1_out, rt_out, valid_out);
      end
      tests_run++;
      if (obs !== pack(8'b0100_0010, 32'h5, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 1'b1)) begin
         tests_failed++;
         $display("FAIL load_all got %h", obs);
      end
      check_cnt("load");
   endtask

   task automatic test_stall();
      logic [151:0] held;
      // lw: MemtoReg, RegWrite, MemRead, ALUSrc, ALUOp=00
      set_in(1'b1, 8'b1110_0100, 32'h0000_0100, 32'h0000_0007, 32'h0000_0010,
             32'h0000_0404, 5'd3, 5'd8, 5'd0);
      step();
      held = pack(8'b1110_0100, 32'h100, 32'h7, 32'h10, 32'h404, 5'd3, 5'd8, 5'd0, 1'b1);
      tests_run++;
      if (obs !== held) begin
         tests_failed++;
         $display("FAIL stall_lw_load got %h want %h", obs, held);
      end
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_in(k[0], 8'h10 + 8'(k), 32'hC0DE_0000 + 32'(k), 32'hFFFF_FFFF, 32'h1,
                32'h2, 5'd30, 5'd29, 5'd28);
         step();
         tests_run++;
         if (obs !== held) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d] got %h want %h", k, obs, held);
         end
      end
      check_cnt("stall");
      stall = 1'b0;
      set_in(1'b1, 8'b0100_1010, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFF0,
             32'h0000_0408, 5'd4, 5'd5, 5'd6);
      step();
      tests_run++;
      if (obs !== pack(8'b0100_1010, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h408,
                       5'd4, 5'd5, 5'd6, 1'b1)) begin
         tests_failed++;
         $display("FAIL stall_release got %h", obs);
      end
   endtask

   task automatic test_flush_over_stall();
      stall = 1'b1; flush = 1'b1;
      set_in(1'b1, 8'b0001_0100, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
             32'h4444_4444, 5'd7, 5'd8, 5'd9);
      step();
      tests_run++;
      if (obs !== 152'd0) begin
         tests_failed++;
         $display("FAIL flush_over_stall got %h want 0", obs);
      end
      check_cnt("flush_over_stall");
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_mux_bubble();
      set_in(1'b0, 8'b0101_0000, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_0020,
             32'h0000_0500, 5'd10, 5'd11, 5'd12);
      step();
      tests_run++;
      if ({ALUOp_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
           RegDst_out, ALUSrc_out, valid_out} !== 9'd0) begin
         tests_failed++;
         $display("FAIL mux_bubble_ctrl got RegWrite=%b MemWrite=%b valid=%b want 0",
                  RegWrite_out, MemWrite_out, valid_out);
      end
      tests_run++;
      if (rd2_out !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL mux_bubble_rd2 got %h want deadbeef", rd2_out);
      end
      tests_run++;
      if (obs !== pack(8'h00, 32'hAA, 32'hDEAD_BEEF, 32'h20, 32'h500,
                       5'd10, 5'd11, 5'd12, 1'b0)) begin
         tests_failed++;
         $display("FAIL mux_bubble_all got %h", obs);
      end
      check_cnt("mux_bubble");
   endtask

   task automatic test_back_to_back();
      logic [7:0]  c [4] = '{8'hFF, 8'h0C, 8'h81, 8'h3D};
      logic [31:0] a [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h5A5A_A5A5};
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, c[k], a[k], ~a[k], a[k] ^ 32'h0F0F_0F0F, 32'h0040_0000 + 32'(4 * k),
                5'(k), 5'(31 - k), 5'(k + 16));
         step();
         tests_run++;
         if (obs !== pack(c[k], a[k], ~a[k], a[k] ^ 32'h0F0F_0F0F,
                          32'h0040_0000 + 32'(4 * k), 5'(k), 5'(31 - k), 5'(k + 16), 1'b1)) begin
            tests_failed++;
            $display("FAIL back_to_back[%0d] got %h", k, obs);
         end
      end
      // plain flush then reset while stalled
      flush = 1'b1;
      step();
      flush = 1'b0;
      tests_run++;
      if (obs !== 152'd0) begin
         tests_failed++;
         $display("FAIL flush_plain got %h want 0", obs);
      end
      set_in(1'b1, 8'hC3, 32'h7, 32'h8, 32'h9, 32'hA, 5'd1, 5'd2, 5'd3);
      step();
      stall = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (obs !== 152'd0) begin
         tests_failed++;
         $display("FAIL reset_midstream got %h want 0", obs);
      end
      check_cnt("reset_midstream");
      stall = 1'b0;
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_saturation();
      flush = 1'b1;
      for (int k = 0; k < 65540; k++) step();
      flush = 1'b0;
      tests_run++;
      if (bubble_cnt !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL saturation got %h want ffff", bubble_cnt);
      end
      check_cnt("saturation");
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (bubble_cnt !== 16'h0000) begin
         tests_failed++;
         $display("FAIL saturation_clear got %h want 0", bubble_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_stall();
      test_flush_over_stall();
      test_mux_bubble();
      test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
      test_saturation();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
